// File: rtl/seg_pkg.sv
// Shared constants, FSM encoding and segment table for the 4-digit scanner.
// Segment patterns are hgfedcba, active-high.
package seg_pkg;

  localparam int SCAN_DIV_DEF  = 50000;
  localparam int BLANK_CYC_DEF = 4;
  localparam int NUM_DIG       = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_st_e;

  function automatic logic [7:0] seg_encode(
    input logic [3:0] code
  );
    logic [7:0] s;
    case (code)
      4'd0:    s = 8'b0011_1111;
      4'd1:    s = 8'b0000_0110;
      4'd2:    s = 8'b0101_1011;
      4'd3:    s = 8'b0100_1111;
      4'd4:    s = 8'b0110_0110;
      4'd5:    s = 8'b0110_1101;
      4'd6:    s = 8'b0111_1101;
      4'd7:    s = 8'b0000_0111;
      4'd8:    s = 8'b0111_1111;
      4'd9:    s = 8'b0110_1111;
      // non-BCD codes light only the decimal point
      default: s = 8'b1000_0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// Registered BCD to 7-segment decoder; adds one cycle of latency.
// Reset-free: the scanner keeps the segment lines blanked until valid.
module seg_scan_ctrl_decoder
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] num,
  output logic [7:0] dig
);

  always_ff @(posedge clk) begin
    dig <= seg_encode(num);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller with blanking,
// leading-zero suppression and frame-synchronous double buffering.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_valid,
  input  logic [15:0]        upd_data,
  input  logic               lz_en,
  output logic [7:0]         seg,
  output logic [NUM_DIG-1:0] an,
  output logic               frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIG);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIG - 1);

  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_d;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_d;
  scan_st_e           state;
  scan_st_e           state_d;
  logic [15:0]        shadow;
  logic [15:0]        pending;
  logic               pend_flag;
  logic [3:0]         num;
  logic [3:0]         cur_dig;
  logic [NUM_DIG-1:0] supp;
  logic               slot_end;
  logic               frame_end;

  assign slot_end    = (cnt == CNT_MAX);
  assign frame_end   = slot_end && (idx == IDX_MAX);
  assign frame_start = (cnt == '0) && (idx == '0);
  assign cur_dig     = shadow[{idx, 2'b00} +: 4];

  // A digit is dark when it and every digit to its left are zero.
  assign supp[3] = lz_en && (shadow[15:12] == 4'd0);
  assign supp[2] = supp[3] && (shadow[11:8] == 4'd0);
  assign supp[1] = supp[2] && (shadow[7:4] == 4'd0);
  assign supp[0] = 1'b0;

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt + CW'(1);
    idx_d   = slot_end ? idx + IW'(1) : idx;
    state_d = (cnt_d < BLK_END) ? ST_BLANK : ST_SHOW;
    an      = '1;
    unique case (state)
      ST_SHOW: begin
        if (!supp[idx]) begin
          an = ~({{(NUM_DIG-1){1'b0}}, 1'b1} << idx);
        end
      end
      default: an = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      state     <= ST_BLANK;
      num       <= 4'd0;
      shadow    <= 16'h0000;
      pending   <= 16'h0000;
      pend_flag <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      idx   <= idx_d;
      state <= state_d;
      if (cnt == '0) begin
        num <= cur_dig;
      end
      if (frame_end && pend_flag) begin
        shadow <= pending;
      end
      // a same-cycle update lands in pending and stays flagged
      if (upd_valid) begin
        pending   <= upd_data;
        pend_flag <= 1'b1;
      end else if (frame_end) begin
        pend_flag <= 1'b0;
      end
    end
  end

  seg_scan_ctrl_decoder u_dec (
    .clk (clk),
    .num (num),
    .dig (seg)
  );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl against a position-based model.
// Small geometry: 8 cycles per digit, 2 blank cycles, 32-cycle frame.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;
  localparam logic [7:0] LUT [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0;
  logic        lz_en = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
    bit         chk_seg;
    int         p;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  int          p = 0;
  bit          mvalid = 0;
  logic [15:0] msh = 16'h0;
  logic [15:0] mpv = 16'h0;
  bit          mpend = 0;
  bit          lz_q = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_data    (upd_data),
    .lz_en       (lz_en),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  function automatic exp_t predict();
    exp_t e;
    int c, d, v;
    bit dark;
    c = p % SD;
    d = (p / SD) % 4;
    v = int'((msh >> (4 * d)) & 16'hF);
    dark = lz_q && (d > 0) && ((msh >> (4 * d)) == 16'h0);
    e.an = (c < BC || dark) ? 4'hF : (4'hF ^ (4'h1 << d));
    e.seg = (v > 9) ? 8'h80 : LUT[v];
    e.chk_seg = (c >= 2);
    e.fs = (p % FR == 0);
    e.p = p;
    return e;
  endfunction

  task automatic step(input bit uv, input logic [15:0] ud, input bit r);
    @(posedge clk);
    #1;
    upd_valid = uv;
    upd_data  = ud;
    rst       = r;
    lz_en     = lz_q;
    if (mvalid) q.push_back(predict());
    if (r) begin
      mvalid = 1;
      p = 0;
      msh = 16'h0;
      mpv = 16'h0;
      mpend = 0;
    end else if (mvalid) begin
      if (p % FR == FR - 1 && mpend) begin
        msh = mpv;
        mpend = 0;
      end
      if (uv) begin
        mpv = ud;
        mpend = 1;
      end
      p++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0);
  endtask

  task automatic align(input int k);
    while (p % FR != k) step(0, 16'h0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (an !== e.an) begin
        n_fail++;
        $display("FAIL an p=%0d got %b want %b", e.p, an, e.an);
      end
      n_chk++;
      if (frame_start !== e.fs) begin
        n_fail++;
        $display("FAIL frame_start p=%0d got %b want %b",
                 e.p, frame_start, e.fs);
      end
      if (e.chk_seg) begin
        n_chk++;
        if (seg !== e.seg) begin
          n_fail++;
          $display("FAIL seg p=%0d got %b want %b", e.p, seg, e.seg);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1);
    run(40);
    align(10);
    step(1, 16'h1234, 0);
    run(70);
    lz_q = 1;
    step(1, 16'h0045, 0);
    run(70);
    step(1, 16'h0000, 0);
    run(70);
    lz_q = 0;
    align(5);
    step(1, 16'h1111, 0);
    step(1, 16'h2222, 0);
    run(70);
    align(3);
    step(1, 16'h9999, 0);
    align(FR - 1);
    step(1, 16'h5678, 0);
    run(70);
    step(1, 16'hFA0B, 0);
    run(70);
    step(1, 16'h4321, 0);
    align(2 * SD + 5);
    step(0, 16'h0, 1);
    run(40);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) lz_q = ~lz_q;
      step($urandom_range(0, 15) == 0, 16'($urandom), 0);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range > BLANK_CYC.
REQ-002 The block SHALL have parameter BLANK_CYC, default 4: blanked cycles at the start of each slot; minimum 2.
REQ-003 The block SHALL have one clock and a synchronous active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 upd_valid  in  1  single-cycle request to load a new display value.
REQ-007 upd_data  in  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 lz_en  in  1  leading-zero suppression enable.
REQ-009 seg  out  8  segment pattern (hgfedcba), active-high.
REQ-010 an  out  4  digit enables, active-low; an[i] selects digit i.
REQ-011 frame_start  out  1  single-cycle pulse marking the first cycle of each scan frame.

Function
REQ-012 The block SHALL hold a slot counter cnt (0..SCAN_DIV-1) and a digit index idx (0..3); cnt wraps to 0 after SCAN_DIV-1 and idx then increments, wrapping 3->0.
REQ-013 The FSM SHALL have two states: BLANK while cnt < BLANK_CYC, SHOW while cnt >= BLANK_CYC.
REQ-014 In BLANK, an SHALL be 4'b1111.
REQ-015 In SHOW, an SHALL drive bit idx low and all other bits high, unless the digit is suppressed (REQ-019), in which case an = 4'b1111.
REQ-016 The registered digit code num SHALL load shadow[idx] on the cycle cnt becomes 0.
REQ-017 The decoder SHALL add one cycle of latency, so seg is valid from cnt = 2 onward; BLANK_CYC >= 2 guarantees no ghosting.
REQ-018 Codes above 9 SHALL pass to the decoder unchanged and display as the decimal-point-only pattern 8'b10000000.
REQ-019 With lz_en = 1, digit i (i = 3..1) SHALL be suppressed when shadow[i] and all higher shadow digits are 0.
REQ-020 Digit 0 SHALL never be suppressed.
REQ-021 upd_valid SHALL write upd_data to a pending register and set pend_flag.
REQ-022 If upd_valid is asserted again before the frame boundary, the last value SHALL win.
REQ-023 On the transition into idx = 0, cnt = 0, if pend_flag = 1, the shadow register SHALL load the pending value and pend_flag SHALL clear.
REQ-024 Shadow updates SHALL occur at the frame boundary only, so a frame never tears.
REQ-025 If upd_valid coincides with the frame-boundary load, the shadow register SHALL take the old pending value, the pending register SHALL take the new data, and pend_flag SHALL remain 1.
REQ-026 frame_start SHALL be 1 exactly in cycles where idx = 0 and cnt = 0.
REQ-027 The frame period SHALL be 4*SCAN_DIV cycles.

Reset
REQ-028 While rst = 1 at a clock edge, the block SHALL set cnt = 0, idx = 0, state = BLANK, an = 4'b1111, num = 0, shadow = 16'h0000, pending = 16'h0000, pend_flag = 0.
REQ-029 The first cycle after reset release SHALL have frame_start = 1.
REQ-030 seg SHALL equal 8'b00111111 one cycle after num = 0 is registered.
REQ-031 rst asserted mid-slot or mid-frame SHALL abandon the slot, discard any pending update, and restart at digit 0.

Structure
REQ-032 SCAN_DIV/BLANK_CYC defaults, the digit count (4) and the FSM state encoding SHALL live in a shared package, seg_pkg.
REQ-033 The block SHALL instantiate the existing decoder module as its single sub-module: num -> decoder.num, decoder.dig -> seg, clk shared.
REQ-034 The counter, FSM, shadow/pending registers and suppression logic SHALL live in seg_scan_ctrl.

Verification (SCAN_DIV = 8, BLANK_CYC = 2)
REQ-035 Reset, no update -> an cycles 1111 x2 then 1110 x6, 1111 x2, 1101 x6, and so on; seg = 8'b00111111 during every SHOW; frame_start every 32 cycles.
REQ-036 upd_data = 16'h1234 mid-frame -> current frame still shows 0000; next frame digit 0 seg = 8'b01100110 (4) and digit 3 seg = 8'b00000110 (1).
REQ-037 lz_en = 1, value 16'h0045 -> digits 3 and 2 keep an = 1111 throughout SHOW; digit 1 shows 4, digit 0 shows 5. Value 16'h0000 -> only digit 0 is lit, showing 0.
REQ-038 upd_valid with 16'h1111 then 16'h2222 in the same frame -> the next frame shows 2222.
REQ-039 upd_valid in the same cycle as the frame-boundary load -> that frame shows the prior pending value and the following frame shows the new one.
REQ-040 rst pulsed at digit 2, cnt = 5 with an update pending -> the next cycle has frame_start = 1, idx = 0, an = 1111, and the display shows 0000.
